// File: rtl/uart_prog_loader.sv
// UART boot loader: receives 8N1 bytes, packs them little-endian into 32-bit
// words and streams them into instruction memory while the core is held off.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 14,
  parameter int IDLE_TIMEOUT = 1000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              rx,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [31:0]       prog_wdata,
  output logic              loading,
  output logic              done,
  output logic              frame_err,
  output logic [ADDR_W:0]   word_count
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_TIMEOUT);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_t;

  rx_state_t         state_q, state_d;
  logic              rx_p0, rx_p1, rx_p2;
  logic              rx_fall;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [2:0]        bit_idx_q;
  logic [7:0]        sh_q;
  logic [1:0]        byte_idx_q;
  logic [23:0]       word_q;
  logic [IDLE_W-1:0] idle_cnt_q;
  logic              cnt_clr, shift_en, stop_ok, stop_bad;
  logic              session_go, timeout;

  // Stage p0/p1: synchronizer, resets to idle-high; p2 is the edge-detect history
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  assign rx_fall = rx_p2 & ~rx_p1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_fall) begin
          state_d = S_START;
          cnt_clr = 1'b1;
        end
      end
      S_START: begin
        if (bit_cnt_q == HALF_LAST) begin
          cnt_clr = 1'b1;
          state_d = rx_p1 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bit_cnt_q == BIT_LAST) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_cnt_q == BIT_LAST) begin
          cnt_clr  = 1'b1;
          state_d  = S_IDLE;
          stop_ok  = rx_p1;
          stop_bad = ~rx_p1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
    end else begin
      bit_cnt_q <= (cnt_clr || state_q == S_IDLE) ? '0 : bit_cnt_q + CNT_W'(1);
      if (state_q != S_DATA) bit_idx_q <= '0;
      else if (shift_en)     bit_idx_q <= bit_idx_q + 3'd1;
    end
  end

  // Byte and word staging are pure data; only byte_idx_q qualifies them
  always_ff @(posedge clock) begin
    if (shift_en) sh_q <= {rx_p1, sh_q[7:1]};
    if (stop_ok) begin
      case (byte_idx_q)
        2'd0:    word_q[7:0]   <= sh_q;
        2'd1:    word_q[15:8]  <= sh_q;
        2'd2:    word_q[23:16] <= sh_q;
        default: ;
      endcase
    end
  end

  assign session_go = start & ~loading;
  assign timeout    = (idle_cnt_q == IDLE_MAX) && (word_count != '0);

  // Saturating idle-line counter; any receiver activity or low line clears it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idle_cnt_q <= '0;
    end else if (session_go) begin
      idle_cnt_q <= '0;
    end else if (state_q == S_IDLE && rx_p1) begin
      if (idle_cnt_q != IDLE_MAX) idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
    end else begin
      idle_cnt_q <= '0;
    end
  end

  // Stage p1: word commit; the write strobe follows the 4th stop-bit sample
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prog_we    <= 1'b0;
      prog_addr  <= '0;
      prog_wdata <= '0;
      loading    <= 1'b0;
      done       <= 1'b0;
      frame_err  <= 1'b0;
      word_count <= '0;
      byte_idx_q <= '0;
    end else begin
      prog_we <= 1'b0;
      if (session_go) begin
        loading    <= 1'b1;
        done       <= 1'b0;
        frame_err  <= 1'b0;
        prog_addr  <= '0;
        word_count <= '0;
        byte_idx_q <= '0;
      end else if (loading) begin
        if (prog_we) begin
          word_count <= word_count + (ADDR_W + 1)'(1);
          if (prog_addr == ADDR_LAST) begin
            loading <= 1'b0;
            done    <= 1'b1;
          end else begin
            prog_addr <= prog_addr + ADDR_W'(1);
          end
        end else if (timeout) begin
          loading    <= 1'b0;
          done       <= 1'b1;
          byte_idx_q <= '0;
        end else if (stop_bad) begin
          frame_err <= 1'b1;
        end else if (stop_ok) begin
          byte_idx_q <= byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            prog_we    <= 1'b1;
            prog_wdata <= {sh_q, word_q};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: expected writes go into a scoreboard
// queue and a negedge monitor checks every prog_we against it.
module tb_uart_prog_loader;

  localparam int CPB = 4;
  localparam int AW  = 4;
  localparam int TO  = 200;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          rx    = 1'b1;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_wdata;
  logic          loading, done, frame_err;
  logic [AW:0]   word_count;

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] exp_addr_q[$];
  logic [31:0]   exp_data_q[$];

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .IDLE_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .start(start), .rx(rx),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .loading(loading), .done(done), .frame_err(frame_err), .word_count(word_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard and occur while loading
  always @(negedge clock) begin
    if (prog_we === 1'b1) begin
      logic [AW-1:0] ea;
      logic [31:0]   ed;
      checks++;
      if (exp_addr_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr %0h data %0h want no write", prog_addr, prog_wdata);
      end else begin
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        if (prog_addr !== ea || prog_wdata !== ed || loading !== 1'b1) begin
          errors++;
          $display("FAIL write got addr %0h data %0h loading %0b want addr %0h data %0h loading 1",
                   prog_addr, prog_wdata, loading, ea, ed);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic expect_write(input logic [AW-1:0] a, input logic [31:0] d);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && exp_addr_q.size() != 0; i++) @(negedge clock);
    check(name, exp_addr_q.size(), 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_loading", loading, 0);
    check("rst_done", done, 0);
    check("rst_addr", prog_addr, 0);
    check("rst_count", word_count, 0);
    check("rst_we", prog_we, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("idle_no_load", loading, 0);

    // Single word 0x12345678
    pulse_start();
    check("start_loading", loading, 1);
    check("start_count", word_count, 0);
    expect_write(4'd0, 32'h12345678);
    send_word(32'h12345678);
    drain("drain_w0");
    check("count_after_w0", word_count, 1);
    check("addr_after_w0", prog_addr, 1);

    // Second word, a partial byte, then idle timeout
    expect_write(4'd1, 32'hDEADBEEF);
    send_word(32'hDEADBEEF);
    drain("drain_w1");
    send_byte(8'h99, 1'b1);
    repeat (TO + 30) @(negedge clock);
    check("to_loading", loading, 0);
    check("to_done", done, 1);
    check("to_count", word_count, 2);

    // Framing error mid-word: good 11, bad EE, good 22 33 44
    pulse_start();
    check("restart_done", done, 0);
    check("restart_count", word_count, 0);
    check("restart_ferr", frame_err, 0);
    send_byte(8'h11, 1'b1);
    send_byte(8'hEE, 1'b0);
    check("ferr_set", frame_err, 1);
    expect_write(4'd0, 32'h44332211);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    drain("drain_ferr");
    check("ferr_count", word_count, 1);

    // One-clock glitch mid-word is not a byte
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    rx = 1'b0;
    @(negedge clock);
    rx = 1'b1;
    repeat (12) @(negedge clock);
    check("glitch_count", word_count, 1);
    check("glitch_loading", loading, 1);
    check("glitch_ferr", frame_err, 1);
    expect_write(4'd1, 32'hDDCCBBAA);
    send_byte(8'hCC, 1'b1);
    send_byte(8'hDD, 1'b1);
    drain("drain_glitch");
    repeat (TO + 30) @(negedge clock);
    check("to2_done", done, 1);

    // No timeout while no word has arrived
    pulse_start();
    repeat (TO + 100) @(negedge clock);
    check("empty_loading", loading, 1);
    check("empty_done", done, 0);

    // Fill all 16 addresses, then a 17th word is ignored
    for (int i = 0; i < 16; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      expect_write(4'(i), {8'hA5, iv, 8'h5A, ~iv});
      send_word({8'hA5, iv, 8'h5A, ~iv});
    end
    drain("drain_fill");
    check("full_loading", loading, 0);
    check("full_done", done, 1);
    check("full_count", word_count, 16);
    check("full_addr", prog_addr, 15);
    send_word(32'h0BADF00D);
    check("extra_count", word_count, 16);

    // Reset mid-word aborts the session
    pulse_start();
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    reset = 1'b0;
    #1;
    check("mid_rst_loading", loading, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_wdata", prog_wdata, 0);
    check("mid_rst_addr", prog_addr, 0);
    check("mid_rst_count", word_count, 0);
    check("mid_rst_we", prog_we, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    check("post_rst_count", word_count, 0);
    pulse_start();
    expect_write(4'd0, 32'hCAFEF00D);
    send_word(32'hCAFEF00D);
    drain("drain_post_rst");
    check("post_rst_addr", prog_addr, 1);

    repeat (5) @(negedge clock);
    check("sb_empty", exp_addr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
